// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and defaults for the serial adder
package adder_pkg;

  // Default operand width for the arithmetic library serial adder
  localparam int ADDER_WIDTH_DEF = 8;

  // Controller states: waiting, shifting bits, one-cycle completion
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational 1-bit full adder
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic p;

  // Propagate term is shared between sum and carry
  assign p     = a ^ b;
  assign sum   = p ^ c;
  assign carry = (a & b) | (c & p);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder with start/busy/done handshake
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 sum bits produced so far; the final bit comes straight from the cell
  logic [WIDTH-2:0] s_sh;
  logic             carry_q;
  logic             c_msb_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             cell_sum;
  logic             cell_carry;
  logic             load;
  logic             in_run;

  // The one and only arithmetic element: LSBs of both operands plus the running carry
  fa_cell u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry_q),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  assign in_run = (state_q == RUN);
  assign load   = start && ((state_q == IDLE) || (state_q == DONE));

  // State register; reset wins over any start in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: accept only from IDLE/DONE, leave RUN after the last bit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode directly from the state flop, so they are glitch-free and input-independent
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operand/sum shifting, carry chain, bit counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load) begin
      a_sh    <= a;
      b_sh    <= b;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (in_run) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      s_sh    <= (WIDTH-1)'({cell_sum, s_sh} >> 1);
      carry_q <= cell_carry;
      cnt_q   <= cnt_q + CW'(1);
      // Carry out of bit WIDTH-2 is the carry into the MSB, needed for signed overflow
      if (cnt_q == PENULT) begin
        c_msb_q <= cell_carry;
      end
      // Results are only touched here, so they hold through IDLE and the next RUN
      if (cnt_q == LAST) begin
        sum_q  <= {cell_sum, s_sh};
        cout_q <= cell_carry;
        ovf_q  <= c_msb_q ^ cell_carry;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=4)
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  int tests = 0;
  int fails = 0;
  int prev_sum, prev_cout, prev_ovf;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned sum for result/carry, true signed sum out of range for overflow
  function automatic void model(input int w, input int a, input int b, input int c,
                                output int s, output int co, output int ov);
    int t, sa, sb, st, half;
    half = 1 << (w - 1);
    t    = a + b + c;
    s    = t % (1 << w);
    co   = t >> w;
    sa   = (a >= half) ? a - 2 * half : a;
    sb   = (b >= half) ? b - 2 * half : b;
    st   = sa + sb + c;
    ov   = (st >= half || st < -half) ? 1 : 0;
  endfunction

  task automatic run8(input int a, input int b, input int c, input bit mid_start);
    int es, ec, eo, lat, extra;
    bit both;
    model(8, a, b, c, es, ec, eo);
    a8 = 8'(a); b8 = 8'(b); cin8 = c[0]; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("busy_after_accept", busy8, 1);
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 0; both = 0;
    while (!done8 && lat < 40) begin
      if (busy8 && done8) both = 1;
      if (lat == 4) chk("sum_hold_in_run", sum8, prev_sum);
      start8 = (mid_start && lat == 2);
      tick();
      lat++;
    end
    start8 = 1'b0;
    chk("latency8", lat, 8);
    chk("busy_done_exclusive", both, 0);
    chk("busy_at_done", busy8, 0);
    chk("sum8", sum8, es);
    chk("cout8", cout8, ec);
    chk("ovf8", ovf8, eo);
    prev_sum = es; prev_cout = ec; prev_ovf = eo;
    if (mid_start) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (done8) extra++;
      end
      chk("single_done_pulse", extra, 0);
      chk("sum_hold_idle", sum8, es);
    end
  endtask

  task automatic run4(input int a, input int b, input int c);
    int es, ec, eo, lat;
    model(4, a, b, c, es, ec, eo);
    a4 = 4'(a); b4 = 4'(b); cin4 = c[0]; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    lat = 0;
    while (!done4 && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency4", lat, 4);
    chk("sum4", sum4, es);
    chk("cout4", cout4, ec);
    chk("ovf4", ovf4, eo);
  endtask

  initial begin
    int es, ec, eo, n, ra, rb, rc, extra;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_cout8", cout8, 0);
    chk("rst_ovf8", ovf8, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_sum4", sum4, 0);
    prev_sum = 0; prev_cout = 0; prev_ovf = 0;

    // Directed cases from the plan
    run8('h0F, 'h01, 0, 0);
    run8('hFF, 'h01, 0, 0);
    run8('h7F, 'h01, 0, 0);
    run8('h80, 'h80, 1, 1);

    // Back-to-back: start held high, fresh operands presented in each DONE cycle
    ra = $urandom_range(0, 255); rb = $urandom_range(0, 255); rc = $urandom_range(0, 1);
    model(8, ra, rb, rc, es, ec, eo);
    a8 = 8'(ra); b8 = 8'(rb); cin8 = rc[0]; start8 = 1'b1;
    tick();
    n = 0;
    for (int k = 0; k < 5; k++) begin
      while (!done8 && n < 40) begin
        if (n == 4) chk("b2b_sum_hold", sum8, prev_sum);
        tick();
        n++;
      end
      chk("b2b_interval", n, (k == 0) ? 8 : 9);
      chk("b2b_sum", sum8, es);
      chk("b2b_cout", cout8, ec);
      chk("b2b_ovf", ovf8, eo);
      prev_sum = es; prev_cout = ec; prev_ovf = eo;
      ra = $urandom_range(0, 255); rb = $urandom_range(0, 255); rc = $urandom_range(0, 1);
      model(8, ra, rb, rc, es, ec, eo);
      a8 = 8'(ra); b8 = 8'(rb); cin8 = rc[0];
      tick();
      n = 1;
    end
    start8 = 1'b0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_tail_sum", sum8, es);
    prev_sum = es; prev_cout = ec; prev_ovf = eo;
    tick();

    // Reset on the 4th RUN edge, with a simultaneous start that must be ignored
    a8 = 8'h55; b8 = 8'h66; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; start8 = 1'b1;
    tick();
    rst = 1'b0; start8 = 1'b0;
    chk("midrst_busy", busy8, 0);
    chk("midrst_done", done8, 0);
    chk("midrst_sum", sum8, 0);
    chk("midrst_cout", cout8, 0);
    chk("midrst_ovf", ovf8, 0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) extra++;
    end
    chk("midrst_quiet", extra, 0);
    prev_sum = 0; prev_cout = 0; prev_ovf = 0;
    run8('h12, 'h34, 0, 0);
    chk("sum_12_34", sum8, 'h46);

    // Random operands
    for (int i = 0; i < 20; i++) begin
      run8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), 0);
    end

    // Exhaustive 4-bit sweep
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          run4(x, y, c);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
